interrupt_sequencer: RTL
========================

# interrupt_sequencer

Clocked control core of the 8259A-compatible PIC. It holds the interrupt request (IRR) and in-service (ISR) registers and resolves fixed priority with nesting and masking. It drives INT to the CPU and runs the two-pulse INTA acknowledge sequence, producing the frozen level, pulse index and 8-bit vector. End-of-interrupt commands from the OCW2 decoder and ICW4 auto-EOI mode retire in-service levels.

## Interface
- No parameters. Level count is fixed at 8 (package constant).
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- IR  in  8  request lines, synchronous to clk
- IMR  in  8  mask (OCW1); 1 = masked
- LTIM  in  1  1 = level-triggered, 0 = edge-triggered (ICW1)
- AEOI  in  1  auto-EOI enable (ICW4)
- AddressBase  in  8  ICW2; bits [7:3] used, [2:0] ignored
- INTA  in  1  active-low acknowledge from CPU, asynchronous
- eoiValid  in  1  one-cycle EOI command strobe
- eoiSpecific  in  1  1 = specific EOI, 0 = non-specific
- eoiLevel  in  3  target level for specific EOI
- INT  out  1  interrupt request to CPU
- highestPriority  out  3  level frozen at first INTA
- currentPulse  out  1  0 during/after pulse 1, 1 after pulse 1 ends, until sequence end
- vectorValid  out  1  high while the second INTA pulse is low
- vector  out  8  AddressBase[7:3] concatenated with highestPriority
- IRR  out  8  request register status
- ISRreg  out  8  in-service register status

## Operation
- Reset: IRR, ISRreg, INT, highestPriority, currentPulse, vectorValid, vector all 0. State IDLE.
- INTA path:
  - INTA passes through a 2-flop synchronizer plus one history flop.
  - fallEdge = history & ~sync2; riseEdge = ~history & sync2.
- IRR, edge mode: bit sets on a 0→1 of IR (IR registered one cycle). Bit holds until acknowledged.
- IRR, level mode: bit mirrors IR each cycle, except the bit cleared by acknowledge.
- Eligible level:
  - Lowest-numbered bit of IRR & ~IMR (IR0 highest priority).
  - Must also be strictly higher priority than the highest set ISRreg bit (fully nested).
- FSM states: IDLE, WAIT1, PULSE1, GAP, PULSE2.
- IDLE: eligible level exists → WAIT1, INT=1.
- IDLE: fallEdge with no request (spurious) → PULSE1 with highestPriority=7, no ISRreg set, no IRR clear.
- WAIT1: eligible vanishes (masked, level-mode withdrawal, or EOI-unrelated nesting change) → IDLE, INT=0.
- WAIT1: fallEdge → PULSE1.
  - highestPriority ← resolved level.
  - ISRreg[level] ← 1, IRR[level] ← 0.
  - INT ← 0, currentPulse ← 0.
- PULSE1: riseEdge → GAP, currentPulse ← 1.
- GAP: fallEdge → PULSE2, vectorValid ← 1, vector ← {AddressBase[7:3], highestPriority}.
- PULSE2: riseEdge → IDLE.
  - vectorValid ← 0, currentPulse ← 0.
  - If AEOI and not spurious: ISRreg[highestPriority] ← 0.
- EOI, any state:
  - Non-specific clears the highest-priority set ISRreg bit; no-op if ISRreg is 0.
  - Specific clears ISRreg[eoiLevel].
- Same-cycle EOI and acknowledge set: EOI is evaluated on pre-update ISRreg. The acknowledge set wins on the same bit.
- IMR changes take effect for resolution in the next cycle. They never affect an acknowledge already in progress.
- reset asserted mid-sequence: return to IDLE on that edge, all outputs 0. A CPU still in an INTA cycle sees vectorValid=0.

## Timing
- IR edge → IRR bit: 1 cycle. IRR → INT: 1 cycle (registered).
- INTA pin change → registered effect: 3 rising edges after first sampling edge (2 sync + edge detect).
- INTA pulses narrower than 2 clk periods are not guaranteed to be seen. The CPU-side spec requires ≥3 clk low and ≥3 clk high.
- vector is stable for the whole vectorValid window. vectorValid deasserts 3 edges after INTA rises.

## Structure
- Package pic_pkg:
  - state enum (IDLE, WAIT1, PULSE1, GAP, PULSE2).
  - NUM_IR=8.
  - SPURIOUS_LEVEL=3'd7.
  - EOI type encodings.
- Sub-module priority_resolver, combinational:
  - Inputs: IRR, IMR, ISRreg.
  - Outputs: valid and a 3-bit level.
  - Also reused for non-specific EOI target (highest set ISRreg bit).
- Synchronizer is inline, not a separate module.

## Test plan
- Edge mode, IMR=0x00, AddressBase=0x20:
  - Pulse IR[2] high, then two INTA pulses of 5 clk each.
  - Expect: INT=1 two cycles after IR rise; INT=0, ISRreg=0x04, IRR=0x00 after first fall.
  - Expect: currentPulse=1 after first rise; vector=0x22 with vectorValid=1 during second pulse.
- Nesting:
  - ISRreg=0x04 (level 2 in service), raise IR[5] → INT stays 0.
  - Raise IR[1] → INT=1; acknowledge → ISRreg=0x06, vector=0x21.
  - Non-specific EOI → ISRreg=0x04.
- Masking and withdrawal:
  - IMR=0x08, raise IR[3] → INT stays 0.
  - LTIM=1, IR[4] high then low before INTA → INT rises then returns to 0, state IDLE.
- Spurious:
  - No requests, two INTA pulses → highestPriority=7, vector=0x27, ISRreg unchanged at 0x00.
- AEOI=1, IR[6] acknowledged → ISRreg=0x40 during GAP/PULSE2, 0x00 after second rise.
- Same-cycle EOI:
  - Specific EOI level 6 in the same cycle as acknowledge set of level 6 → ISRreg[6]=1.
- Reset in GAP:
  - Assert reset → next cycle all outputs 0, IDLE.
  - Subsequent INTA pulses are treated as spurious.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the 8259A-compatible interrupt sequencer.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned LVL_W  = 3;
  localparam int unsigned VEC_W  = 8;

  localparam logic [LVL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT1  = 3'd1,
    PULSE1 = 3'd2,
    GAP    = 3'd3,
    PULSE2 = 3'd4
  } state_e;

  typedef enum logic {
    EOI_NONSPECIFIC = 1'b0,
    EOI_SPECIFIC    = 1'b1
  } eoi_type_e;

  function automatic logic [NUM_IR-1:0] level_onehot(input logic [LVL_W-1:0] lvl);
    return NUM_IR'(1) << lvl;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Request, mask, acknowledge and status signals between the PIC front end and the sequencer core.
interface interrupt_sequencer_if;
  import pic_pkg::*;

  logic [NUM_IR-1:0] IR;
  logic [NUM_IR-1:0] IMR;
  logic              LTIM;
  logic              AEOI;
  logic [VEC_W-1:0]  AddressBase;
  logic              INTA;
  logic              eoiValid;
  logic              eoiSpecific;
  logic [LVL_W-1:0]  eoiLevel;

  logic              INT;
  logic [LVL_W-1:0]  highestPriority;
  logic              currentPulse;
  logic              vectorValid;
  logic [VEC_W-1:0]  vector;
  logic [NUM_IR-1:0] IRR;
  logic [NUM_IR-1:0] ISRreg;

  modport master (
    output IR, IMR, LTIM, AEOI, AddressBase, INTA, eoiValid, eoiSpecific, eoiLevel,
    input  INT, highestPriority, currentPulse, vectorValid, vector, IRR, ISRreg
  );

  modport slave (
    input  IR, IMR, LTIM, AEOI, AddressBase, INTA, eoiValid, eoiSpecific, eoiLevel,
    output INT, highestPriority, currentPulse, vectorValid, vector, IRR, ISRreg
  );

endinterface

// File: rtl/interrupt_sequencer_priority_resolver.sv
// Fixed-priority resolver: lowest unmasked request, qualified against the highest in-service level.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic [NUM_IR-1:0] isr,
  output logic              valid,
  output logic [LVL_W-1:0]  level
);

  logic [NUM_IR-1:0] req;
  logic              req_found;
  logic [LVL_W-1:0]  req_lvl;
  logic              isr_found;
  logic [LVL_W-1:0]  isr_lvl;

  // Scan downwards so the lowest-numbered set bit is the one left standing.
  always_comb begin
    req       = irr & ~imr;
    req_found = 1'b0;
    req_lvl   = '0;
    isr_found = 1'b0;
    isr_lvl   = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (req[i]) begin
        req_found = 1'b1;
        req_lvl   = LVL_W'(i);
      end
      if (isr[i]) begin
        isr_found = 1'b1;
        isr_lvl   = LVL_W'(i);
      end
    end
  end

  assign valid = req_found && (!isr_found || (req_lvl < isr_lvl));
  assign level = req_lvl;

endmodule

// File: rtl/interrupt_sequencer.sv
// Clocked PIC core: IRR/ISR bookkeeping, nested priority, INT drive and the two-pulse INTA sequence.
module interrupt_sequencer
  import pic_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  interrupt_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [NUM_IR-1:0] imr_q, imr_d;
  logic [NUM_IR-1:0] ir_prev_q, ir_prev_d;
  logic              inta_s1_q, inta_s1_d;
  logic              inta_s2_q, inta_s2_d;
  logic              inta_hist_q, inta_hist_d;
  logic              int_q, int_d;
  logic [LVL_W-1:0]  hp_q, hp_d;
  logic              cp_q, cp_d;
  logic              vv_q, vv_d;
  logic [VEC_W-1:0]  vector_q, vector_d;
  logic              spurious_q, spurious_d;

  logic              fall_c;
  logic              rise_c;
  logic              elig_valid_c;
  logic [LVL_W-1:0]  elig_level_c;
  logic              eoi_valid_c;
  logic [LVL_W-1:0]  eoi_level_c;
  logic [NUM_IR-1:0] isr_set_c;
  logic [NUM_IR-1:0] isr_clr_c;
  logic [NUM_IR-1:0] irr_clr_c;
  logic              addr_low_unused;

  assign addr_low_unused = ^bus.AddressBase[2:0];

  assign fall_c = inta_hist_q & ~inta_s2_q;
  assign rise_c = ~inta_hist_q & inta_s2_q;

  priority_resolver u_req_resolver (
    .irr   (irr_q),
    .imr   (imr_q),
    .isr   (isr_q),
    .valid (elig_valid_c),
    .level (elig_level_c)
  );

  // Same resolver, unmasked and unnested, picks the non-specific EOI target.
  priority_resolver u_eoi_resolver (
    .irr   (isr_q),
    .imr   ('0),
    .isr   ('0),
    .valid (eoi_valid_c),
    .level (eoi_level_c)
  );

  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    hp_d        = hp_q;
    cp_d        = cp_q;
    vv_d        = vv_q;
    vector_d    = vector_q;
    spurious_d  = spurious_q;
    ir_prev_d   = bus.IR;
    imr_d       = bus.IMR;
    inta_s1_d   = bus.INTA;
    inta_s2_d   = inta_s1_q;
    inta_hist_d = inta_s2_q;
    isr_set_c   = '0;
    isr_clr_c   = '0;
    irr_clr_c   = '0;

    if (bus.eoiValid) begin
      if (bus.eoiSpecific == EOI_SPECIFIC) begin
        isr_clr_c = isr_clr_c | level_onehot(bus.eoiLevel);
      end else if (eoi_valid_c) begin
        isr_clr_c = isr_clr_c | level_onehot(eoi_level_c);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (elig_valid_c) begin
          state_d = WAIT1;
          int_d   = 1'b1;
        end else if (fall_c) begin
          state_d    = PULSE1;
          hp_d       = SPURIOUS_LEVEL;
          spurious_d = 1'b1;
          cp_d       = 1'b0;
        end
      end
      WAIT1: begin
        if (fall_c) begin
          state_d = PULSE1;
          int_d   = 1'b0;
          cp_d    = 1'b0;
          if (elig_valid_c) begin
            hp_d       = elig_level_c;
            spurious_d = 1'b0;
            isr_set_c  = level_onehot(elig_level_c);
            irr_clr_c  = level_onehot(elig_level_c);
          end else begin
            hp_d       = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
        end else if (!elig_valid_c) begin
          state_d = IDLE;
          int_d   = 1'b0;
        end
      end
      PULSE1: begin
        if (rise_c) begin
          state_d = GAP;
          cp_d    = 1'b1;
        end
      end
      GAP: begin
        if (fall_c) begin
          state_d  = PULSE2;
          vv_d     = 1'b1;
          vector_d = {bus.AddressBase[7:3], hp_q};
        end
      end
      PULSE2: begin
        if (rise_c) begin
          state_d = IDLE;
          vv_d    = 1'b0;
          cp_d    = 1'b0;
          if (bus.AEOI && !spurious_q) begin
            isr_clr_c = isr_clr_c | level_onehot(hp_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
        vv_d    = 1'b0;
        cp_d    = 1'b0;
      end
    endcase

    if (bus.LTIM) begin
      irr_d = bus.IR;
    end else begin
      irr_d = irr_q | (bus.IR & ~ir_prev_q);
    end
    irr_d = irr_d & ~irr_clr_c;

    // Clears first so an acknowledge set on the same bit survives a same-cycle EOI.
    isr_d = (isr_q & ~isr_clr_c) | isr_set_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      ir_prev_q   <= '0;
      inta_s1_q   <= 1'b1;
      inta_s2_q   <= 1'b1;
      inta_hist_q <= 1'b1;
      int_q       <= 1'b0;
      hp_q        <= '0;
      cp_q        <= 1'b0;
      vv_q        <= 1'b0;
      vector_q    <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      ir_prev_q   <= ir_prev_d;
      inta_s1_q   <= inta_s1_d;
      inta_s2_q   <= inta_s2_d;
      inta_hist_q <= inta_hist_d;
      int_q       <= int_d;
      hp_q        <= hp_d;
      cp_q        <= cp_d;
      vv_q        <= vv_d;
      vector_q    <= vector_d;
      spurious_q  <= spurious_d;
    end
  end

  assign bus.INT             = int_q;
  assign bus.highestPriority = hp_q;
  assign bus.currentPulse    = cp_q;
  assign bus.vectorValid     = vv_q;
  assign bus.vector          = vector_q;
  assign bus.IRR             = irr_q;
  assign bus.ISRreg          = isr_q;

endmodule
